muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential HI/LO unit.
// MULT/MULTU complete after MUL_STAGES stall cycles. DIV/DIVU use a 32-step
// restoring divider followed by one sign-fix cycle. MTHI/MTLO write in one cycle.
// Ports:
//   clk, resetn        clock, async active-low reset
//   op_valid, op_code  operation request (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO)
//   src_a, src_b       rs / rt operands
//   flush              abort the operation in flight and block a same-cycle accept
//   stall              freeze upstream while a MULT/DIV is busy
//   hi, lo             architectural HI/LO
//   done               one-cycle pulse when new MULT/DIV results become visible
module muldiv_seq #(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    // Counter value on the last MUL cycle (unused when MUL_STAGES == 1).
    localparam logic [5:0] MUL_LAST = (MUL_STAGES > 1) ? 6'(MUL_STAGES - 2) : 6'd0;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] opa, opb, rem;      // opa doubles as the quotient shift register
    logic        sgn_r, q_neg, r_neg;
    logic        accept, is_mul, is_div, is_mt;
    logic        mul_wr, div_wr;

    assign accept = (state == IDLE) & op_valid & ~flush;
    assign is_mul = accept & (op_code[2:1] == 2'b00);
    assign is_div = accept & (op_code[2:1] == 2'b01);
    assign is_mt  = accept & ((op_code == OP_MTHI) | (op_code == OP_MTLO));
    assign stall  = (state != IDLE) | is_mul | is_div;

    // Multiplier reads live operands in IDLE so MUL_STAGES == 1 can write at C0.
    logic [31:0]        mx, my;
    logic               msg;
    logic signed [65:0] prod;
    assign mx   = (state == IDLE) ? src_a : opa;
    assign my   = (state == IDLE) ? src_b : opb;
    assign msg  = (state == IDLE) ? (op_code == OP_MULT) : sgn_r;
    assign prod = $signed({{34{msg & mx[31]}}, mx}) * $signed({{34{msg & my[31]}}, my});

    // Operand magnitudes for the divider.
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    assign a_neg = (op_code == OP_DIV) & src_a[31];
    assign b_neg = (op_code == OP_DIV) & src_b[31];
    assign a_abs = a_neg ? -src_a : src_a;
    assign b_abs = b_neg ? -src_b : src_b;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    logic [32:0] r2, diff;
    logic        ge;
    assign r2   = {rem, opa[31]};
    assign diff = r2 - {1'b0, opb};
    assign ge   = ~diff[32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_wr    = 1'b0;
        div_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    if (MUL_STAGES == 1) mul_wr = 1'b1;
                    else                 state_nxt = MUL;
                end else if (is_div) begin
                    state_nxt = DIV;
                end
            end
            MUL: begin
                if (flush) state_nxt = IDLE;
                else if (cnt == MUL_LAST) begin
                    mul_wr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DIV: begin
                if (flush)             state_nxt = IDLE;
                else if (cnt == 6'd31) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
                if (!flush) div_wr = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            rem   <= '0;
            sgn_r <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= mul_wr | div_wr;
            if (is_mul | is_div) begin
                cnt   <= '0;
                rem   <= '0;
                opa   <= is_div ? a_abs : src_a;
                opb   <= is_div ? b_abs : src_b;
                sgn_r <= (op_code == OP_MULT);
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 6'd1;
            end
            if (state == DIV) begin
                rem <= ge ? diff[31:0] : r2[31:0];
                opa <= {opa[30:0], ge};
            end
            if (is_mt) begin
                if (op_code == OP_MTHI) hi <= src_a;
                else                    lo <= src_a;
            end
            if (mul_wr) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end
            if (div_wr) begin
                hi <= r_neg ? -rem : rem;
                lo <= q_neg ? -opa : opa;
            end
        end
    end
endmodule
